// File: rtl/alu_op_sequencer.sv
// Control sequencer: steps one register-transfer ALU command through the data_path strobes.
// Outputs are a Moore decode of the state and latched fields; start is ignored while busy.
module alu_op_sequencer #(
  parameter logic [4:0] NEG_OP = 5'b01000,
  parameter logic [4:0] NOT_OP = 5'b01001,
  parameter logic [4:0] MUL_OP = 5'b01110,
  parameter logic [4:0] DIV_OP = 5'b01111,
  parameter logic [4:0] LDI_OP = 5'b11111
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic        start,
  input  logic [4:0]  opcode,
  input  logic [3:0]  ra,
  input  logic [3:0]  rb,
  input  logic [3:0]  rc,
  output logic        busy,
  output logic        done,
  output logic [4:0]  op_out,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        ZHighin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read
);

  typedef enum logic [2:0] {
    S_IDLE, S_Y, S_Z, S_WLO, S_WHI, S_MDR, S_MW, S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] opcode_q, opcode_d;
  logic [3:0] ra_q, ra_d;
  logic [3:0] rb_q, rb_d;
  logic [3:0] rc_q, rc_d;

  logic is_unary, is_hilo;
  logic [15:0] ra_sel, rb_sel, rc_sel;

  assign is_unary = (opcode_q == NEG_OP) || (opcode_q == NOT_OP);
  assign is_hilo  = (opcode_q == MUL_OP) || (opcode_q == DIV_OP);
  assign ra_sel   = 16'h0001 << ra_q;
  assign rb_sel   = 16'h0001 << rb_q;
  assign rc_sel   = 16'h0001 << rc_q;

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_q  <= S_IDLE;
      opcode_q <= 5'd0;
      ra_q     <= 4'd0;
      rb_q     <= 4'd0;
      rc_q     <= 4'd0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      rc_q     <= rc_d;
    end
  end

  // Fields are only captured on acceptance, so they hold for the whole operation.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    rc_d     = rc_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          opcode_d = opcode;
          ra_d     = ra;
          rb_d     = rb;
          rc_d     = rc;
          if (opcode == LDI_OP)
            state_d = S_MDR;
          else if ((opcode == NEG_OP) || (opcode == NOT_OP))
            state_d = S_Z;
          else
            state_d = S_Y;
        end
      end
      S_Y:     state_d = S_Z;
      S_Z:     state_d = S_WLO;
      S_WLO:   state_d = is_hilo ? S_WHI : S_DONE;
      S_WHI:   state_d = S_DONE;
      S_MDR:   state_d = S_MW;
      S_MW:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = 1'b0;
    op_out   = 5'd0;
    Rout     = 16'd0;
    Rin      = 16'd0;
    Yin      = 1'b0;
    Zlowin   = 1'b0;
    ZHighin  = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    Read     = 1'b0;
    case (state_q)
      S_Y: begin
        op_out = opcode_q;
        Rout   = ra_sel;
        Yin    = 1'b1;
      end
      S_Z: begin
        op_out  = opcode_q;
        Rout    = is_unary ? ra_sel : rb_sel;
        Zlowin  = 1'b1;
        ZHighin = is_hilo;
      end
      S_WLO: begin
        op_out  = opcode_q;
        Zlowout = 1'b1;
        if (is_hilo)
          LOin = 1'b1;
        else
          Rin = rc_sel;
      end
      S_WHI: begin
        op_out   = opcode_q;
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      S_MDR: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      S_MW: begin
        MDRout = 1'b1;
        Rin    = rc_sel;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small behavioural data_path alongside.
module tb_alu_op_sequencer;

  localparam logic [9:0] Y_IN    = 10'h200;
  localparam logic [9:0] ZL_IN   = 10'h100;
  localparam logic [9:0] ZH_IN   = 10'h080;
  localparam logic [9:0] ZL_OUT  = 10'h040;
  localparam logic [9:0] ZH_OUT  = 10'h020;
  localparam logic [9:0] HI_IN   = 10'h010;
  localparam logic [9:0] LO_IN   = 10'h008;
  localparam logic [9:0] MDR_IN  = 10'h004;
  localparam logic [9:0] MDR_OUT = 10'h002;
  localparam logic [9:0] RD      = 10'h001;

  logic        Clock = 1'b0;
  logic        clear;
  logic        start;
  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic        busy, done;
  logic [4:0]  op_out;
  logic [15:0] Rout, Rin;
  logic        Yin, Zlowin, ZHighin, Zlowout, Zhighout, HIin, LOin, MDRin, MDRout, Read;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int viol = 0;
  int n0;

  alu_op_sequencer dut (
    .Clock(Clock), .clear(clear), .start(start), .opcode(opcode),
    .ra(ra), .rb(rb), .rc(rc), .busy(busy), .done(done), .op_out(op_out),
    .Rout(Rout), .Rin(Rin), .Yin(Yin), .Zlowin(Zlowin), .ZHighin(ZHighin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
    .MDRin(MDRin), .MDRout(MDRout), .Read(Read)
  );

  always #5 Clock = ~Clock;

  // Behavioural data_path: register file, Y, Z, HI/LO, MDR on a single bus.
  logic [31:0] rf [16];
  logic [31:0] y_r, zlo_r, zhi_r, hi_r, lo_r, mdr_r, bus, mdatain;
  logic [63:0] prod;

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 32'd0;
    y_r = 0; zlo_r = 0; zhi_r = 0; hi_r = 0; lo_r = 0; mdr_r = 0;
  end

  always_comb begin
    bus = 32'd0;
    for (int i = 0; i < 16; i++) if (Rout[i]) bus = rf[i];
    if (Zlowout)  bus = zlo_r;
    if (Zhighout) bus = zhi_r;
    if (MDRout)   bus = mdr_r;
  end

  assign prod = y_r * bus;

  always @(posedge Clock) begin
    if (Yin) y_r <= bus;
    if (Zlowin) begin
      case (op_out)
        5'b01000: zlo_r <= -bus;
        5'b01001: zlo_r <= ~bus;
        5'b01110: begin zlo_r <= prod[31:0]; zhi_r <= prod[63:32]; end
        default:  zlo_r <= y_r + bus;
      endcase
    end
    if (LOin) lo_r <= bus;
    if (HIin) hi_r <= bus;
    if (Read && MDRin) mdr_r <= mdatain;
    for (int i = 0; i < 16; i++) if (Rin[i]) rf[i] <= bus;
    if (done) done_cnt <= done_cnt + 1;
  end

  // Bus and enable exclusivity, sampled mid-cycle.
  always @(negedge Clock) begin
    if ($countones(Rout) > 1 || $countones(Rin) > 1) viol++;
    if (($countones(Rout) + 32'(Zlowout) + 32'(Zhighout) + 32'(MDRout)) > 1) viol++;
    if (Rout != 16'd0 && Rin != 16'd0) viol++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {15'd0, busy, done, op_out, Rout, Rin,
            Yin, Zlowin, ZHighin, Zlowout, Zhighout, HIin, LOin, MDRin, MDRout, Read};
  endfunction

  function automatic logic [63:0] ev(input logic b, input logic d, input logic [4:0] o,
                                     input logic [15:0] ro, input logic [15:0] ri,
                                     input logic [9:0] s);
    return {15'd0, b, d, o, ro, ri, s};
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Drive a one-cycle start; returns at cycle 1 with inputs scrambled to expose any input leakage.
  task automatic issue(input logic [4:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c);
    opcode = op; ra = a; rb = b; rc = c; start = 1'b1;
    step();
    start = 1'b0; opcode = 5'b10110; ra = 4'd9; rb = 4'd10; rc = 4'd11;
  endtask

  task automatic bin_seq(input string nm, input logic [4:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] c);
    logic [15:0] sa, sb, sc;
    sa = 16'h0001 << a; sb = 16'h0001 << b; sc = 16'h0001 << c;
    issue(op, a, b, c);
    chk({nm, "_c1"}, outs(), ev(1, 0, op, sa, 0, Y_IN));   step();
    chk({nm, "_c2"}, outs(), ev(1, 0, op, sb, 0, ZL_IN));  step();
    chk({nm, "_c3"}, outs(), ev(1, 0, op, 0, sc, ZL_OUT)); step();
    chk({nm, "_c4"}, outs(), ev(1, 1, 0, 0, 0, 0));        step();
    chk({nm, "_c5"}, outs(), 64'd0);
  endtask

  initial begin
    clear = 1'b0; start = 1'b0; opcode = 0; ra = 0; rb = 0; rc = 0; mdatain = 32'd0;
    #1;
    chk("reset_outs", outs(), 64'd0);
    step(); step();
    clear = 1'b1;
    step();

    bin_seq("add", 5'b00011, 4'd2, 4'd3, 4'd1);
    step();

    // R7 <- 12, then R6 <- -R7
    mdatain = 32'd12;
    issue(5'b11111, 4'd0, 4'd0, 4'd7);
    chk("ldi7_c1", outs(), ev(1, 0, 0, 0, 0, RD | MDR_IN));          step();
    chk("ldi7_c2", outs(), ev(1, 0, 0, 0, 16'h0080, MDR_OUT));       step();
    chk("ldi7_c3", outs(), ev(1, 1, 0, 0, 0, 0));                    step();
    chk("r7", rf[7], 32'd12);
    issue(5'b01000, 4'd7, 4'd0, 4'd6);
    chk("neg_c1", outs(), ev(1, 0, 5'b01000, 16'h0080, 0, ZL_IN));   step();
    chk("neg_c2", outs(), ev(1, 0, 5'b01000, 0, 16'h0040, ZL_OUT));  step();
    chk("neg_c3", outs(), ev(1, 1, 0, 0, 0, 0));                     step();
    chk("neg_idle", outs(), 64'd0);
    chk("r6", rf[6], 32'hFFFFFFF4);

    // Multiply: HI/LO written, no register write
    step();
    issue(5'b01110, 4'd4, 4'd5, 4'd9);
    chk("mul_c1", outs(), ev(1, 0, 5'b01110, 16'h0010, 0, Y_IN));          step();
    chk("mul_c2", outs(), ev(1, 0, 5'b01110, 16'h0020, 0, ZL_IN | ZH_IN)); step();
    chk("mul_c3", outs(), ev(1, 0, 5'b01110, 0, 0, ZL_OUT | LO_IN));       step();
    chk("mul_c4", outs(), ev(1, 0, 5'b01110, 0, 0, ZH_OUT | HI_IN));       step();
    chk("mul_c5", outs(), ev(1, 1, 0, 0, 0, 0));                           step();
    chk("mul_idle", outs(), 64'd0);

    issue(5'b11111, 4'd0, 4'd0, 4'd15);
    chk("ldi15_c1", outs(), ev(1, 0, 0, 0, 0, RD | MDR_IN));     step();
    chk("ldi15_c2", outs(), ev(1, 0, 0, 0, 16'h8000, MDR_OUT));  step();
    chk("ldi15_c3", outs(), ev(1, 1, 0, 0, 0, 0));               step();

    // NOT with ra=rc=15
    issue(5'b01001, 4'd15, 4'd3, 4'd15);
    chk("not_c1", outs(), ev(1, 0, 5'b01001, 16'h8000, 0, ZL_IN));  step();
    chk("not_c2", outs(), ev(1, 0, 5'b01001, 0, 16'h8000, ZL_OUT)); step();
    chk("not_c3", outs(), ev(1, 1, 0, 0, 0, 0));                    step();

    // Undefined opcode behaves as binary; ra=rb=rc
    bin_seq("undef", 5'b10101, 4'd0, 4'd0, 4'd0);
    step();

    // Asynchronous clear in the middle of SZ
    n0 = done_cnt;
    issue(5'b00011, 4'd2, 4'd3, 4'd1);
    step();
    chk("rst_sz", outs(), ev(1, 0, 5'b00011, 16'h0008, 0, ZL_IN));
    #2 clear = 1'b0;
    #1 chk("rst_async", outs(), 64'd0);
    step(); step();
    clear = 1'b1;
    repeat (5) step();
    chk("rst_nodone", 64'(done_cnt - n0), 64'd0);
    chk("rst_idle", outs(), 64'd0);

    // start held high: one acceptance every 5 edges
    n0 = done_cnt;
    opcode = 5'b00011; ra = 4'd1; rb = 4'd2; rc = 4'd3; start = 1'b1;
    step();
    chk("hold_c1", outs(), ev(1, 0, 5'b00011, 16'h0002, 0, Y_IN));
    repeat (19) step();
    start = 1'b0;
    chk("hold_dones", 64'(done_cnt - n0), 64'd4);
    chk("hold_idle", outs(), 64'd0);
    step();
    chk("hold_stop", outs(), 64'd0);

    chk("bus_excl", 64'(viol), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
